// File: rtl/wsg_pkg.sv
// Shared types and helpers for the N-voice wave sound generator.
// Voice-index and mix-sum widths are derived from the voice count.
package wsg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_MAC,
        S_OUT
    } state_t;

    localparam logic [2:0] F_FREQ0 = 3'd0;
    localparam logic [2:0] F_FREQ1 = 3'd1;
    localparam logic [2:0] F_FREQ2 = 3'd2;
    localparam logic [2:0] F_FREQ3 = 3'd3;
    localparam logic [2:0] F_FREQ4 = 3'd4;
    localparam logic [2:0] F_WAVE  = 3'd5;
    localparam logic [2:0] F_VOL   = 3'd6;

    localparam int VOICES_MAX = 8;

    // A single voice still needs a 1-bit index register.
    function automatic int vidx_w(input int voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction

    function automatic int sum_w(input int voices);
        return 8 + $clog2(voices);
    endfunction

endpackage

// File: rtl/namco_wsg_nvoice_regs.sv
// Per-voice register file: frequency, waveform and volume nibbles,
// CPU write decode and the sequencer's voice-indexed read port.
module wsg_voice_regs
    import wsg_pkg::*;
#(
    parameter int VOICES = 3,
    parameter int ACC_W  = 20,
    localparam int AD_W   = $clog2(VOICES) + 3,
    localparam int VIDX_W = vidx_w(VOICES)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [AD_W-1:0]   i_ad,
    input  logic [3:0]        i_di,
    input  logic [VIDX_W-1:0] i_rd_voice,
    output logic [ACC_W-1:0]  o_freq,
    output logic [2:0]        o_wave,
    output logic [3:0]        o_vol
);

    logic [ACC_W-1:0]  r_freq [VOICES];
    logic [2:0]        r_wave [VOICES];
    logic [3:0]        r_vol  [VOICES];

    logic [2:0]        w_field;
    logic [VIDX_W-1:0] w_voice;
    logic              w_hit;

    assign w_field = i_ad[2:0];
    assign w_voice = VIDX_W'(i_ad >> 3);
    assign w_hit   = i_wr && (int'(w_voice) < VOICES);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int v = 0; v < VOICES; v++) begin
                r_freq[v] <= '0;
                r_wave[v] <= '0;
                r_vol[v]  <= '0;
            end
        end else if (w_hit) begin
            unique case (1'b1)
                (w_field == F_WAVE): r_wave[w_voice] <= i_di[2:0];
                (w_field == F_VOL):  r_vol[w_voice]  <= i_di;
                default: begin
                    // Nibbles beyond the accumulator width and field 7 fall through.
                    for (int n = 0; n < ACC_W / 4; n++) begin
                        if (w_field == 3'(n))
                            r_freq[w_voice][n*4 +: 4] <= i_di;
                    end
                end
            endcase
        end
    end

    assign o_freq = r_freq[i_rd_voice];
    assign o_wave = r_wave[i_rd_voice];
    assign o_vol  = r_vol[i_rd_voice];

endmodule

// File: rtl/namco_wsg_nvoice.sv
// N-voice wave sound generator: sample divider, voice sequencer,
// phase accumulators and saturating mixer.
module namco_wsg_nvoice
    import wsg_pkg::*;
#(
    parameter int VOICES    = 3,
    parameter int ACC_W     = 20,
    parameter int CLK_DIV   = 500,
    parameter int MIX_SHIFT = $clog2(VOICES),
    localparam int AD_W   = $clog2(VOICES) + 3,
    localparam int VIDX_W = vidx_w(VOICES),
    localparam int SUM_W  = sum_w(VOICES),
    localparam int DIV_W  = $clog2(CLK_DIV)
) (
    input  logic            i_mclk,
    input  logic            i_reset,
    input  logic            i_snden,
    input  logic            i_wr,
    input  logic [AD_W-1:0] i_ad,
    input  logic [3:0]      i_di,
    output logic [7:0]      o_wavead,
    input  logic [3:0]      i_wavedt,
    output logic [7:0]      o_pcmout,
    output logic            o_pcmstb,
    output logic            o_busy,
    output logic            o_ovr
);

    state_t            r_state;
    logic [VIDX_W-1:0] r_v;
    logic [ACC_W-1:0]  r_acc [VOICES];
    logic [DIV_W-1:0]  r_div;
    logic [SUM_W-1:0]  r_sum;
    logic [7:0]        r_wavead;
    logic [7:0]        r_pcmout;
    logic              r_pcmstb;
    logic              r_ovr;

    logic              w_tick;
    logic [ACC_W-1:0]  w_freq;
    logic [2:0]        w_wave;
    logic [3:0]        w_vol;
    logic [ACC_W-1:0]  w_acc_cur;
    logic [ACC_W-1:0]  w_acc_new;
    logic [7:0]        w_prod;
    logic [SUM_W-1:0]  w_sum_nx;
    logic [SUM_W-1:0]  w_mix;
    logic [7:0]        w_sat;
    logic              w_last;

    wsg_voice_regs #(
        .VOICES (VOICES),
        .ACC_W  (ACC_W)
    ) u_regs (
        .i_clk      (i_mclk),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_ad       (i_ad),
        .i_di       (i_di),
        .i_rd_voice (r_v),
        .o_freq     (w_freq),
        .o_wave     (w_wave),
        .o_vol      (w_vol)
    );

    assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_acc_cur = r_acc[r_v];
    assign w_acc_new = i_snden ? (w_acc_cur + w_freq) : w_acc_cur;
    assign w_prod    = {4'b0, i_wavedt} * {4'b0, w_vol};
    assign w_sum_nx  = r_sum + SUM_W'(w_prod);
    assign w_mix     = w_sum_nx >> MIX_SHIFT;
    assign w_sat     = (w_mix > SUM_W'(255)) ? 8'hFF : w_mix[7:0];
    assign w_last    = (r_v == VIDX_W'(VOICES - 1));

    always_ff @(posedge i_mclk) begin
        if (i_reset || w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_v      <= '0;
            r_sum    <= '0;
            r_wavead <= '0;
            r_pcmout <= '0;
            r_pcmstb <= 1'b0;
            r_ovr    <= 1'b0;
            for (int v = 0; v < VOICES; v++)
                r_acc[v] <= '0;
        end else begin
            r_pcmstb <= 1'b0;
            if (w_tick && r_state != S_IDLE)
                r_ovr <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    r_v <= '0;
                    if (w_tick) begin
                        r_sum   <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc[r_v] <= w_acc_new;
                    r_wavead   <= {w_wave, w_acc_new[ACC_W-1 -: 5]};
                    r_state    <= S_WAIT;
                end
                S_WAIT: r_state <= S_MAC;
                S_MAC: begin
                    r_sum <= w_sum_nx;
                    // Final mix is latched with the strobe so both appear in OUT.
                    if (w_last) begin
                        r_pcmout <= i_snden ? w_sat : 8'h00;
                        r_pcmstb <= 1'b1;
                        r_state  <= S_OUT;
                    end else begin
                        r_v     <= r_v + 1'b1;
                        r_state <= S_ACC;
                    end
                end
                S_OUT:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_wavead = r_wavead;
    assign o_pcmout = r_pcmout;
    assign o_pcmstb = r_pcmstb;
    assign o_ovr    = r_ovr;
    // The cycle that accepts a tick already belongs to the sequence.
    assign o_busy   = (r_state != S_IDLE) || w_tick;

endmodule

// File: tb/tb_namco_wsg_nvoice.sv
// Scoreboard bench for the N-voice wave sound generator:
// three instances cover default mixing, saturation and overrun/reset.
module tb_namco_wsg_nvoice;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       snden = 1'b1;
    logic       wr = 1'b0;
    logic [4:0] ad = '0;
    logic [3:0] di = '0;
    logic       rom_a_f = 1'b0, rom_b_f = 1'b0;

    logic [7:0] wa_a, wa_b, wa_c, pcm_a, pcm_b, pcm_c;
    logic [3:0] rd_a, rd_b, rd_c;
    logic       stb_a, stb_b, stb_c, bsy_a, bsy_b, bsy_c;
    logic       ovr_a, ovr_b, ovr_c;

    int n_cmp = 0, n_bad = 0;
    int n_a = 0, n_b = 0, n_c = 0;
    int pops_a = 0, pops_b = 0, stb_cnt_c = 0;
    int busy_a = 0, busy_b = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    namco_wsg_nvoice #(.VOICES(3)) dut_a (
        .i_mclk(clk), .i_reset(rst_a), .i_snden(snden), .i_wr(wr),
        .i_ad(ad), .i_di(di), .o_wavead(wa_a), .i_wavedt(rd_a),
        .o_pcmout(pcm_a), .o_pcmstb(stb_a), .o_busy(bsy_a), .o_ovr(ovr_a));

    namco_wsg_nvoice #(.VOICES(3), .ACC_W(12), .CLK_DIV(16), .MIX_SHIFT(0)) dut_b (
        .i_mclk(clk), .i_reset(rst_b), .i_snden(snden), .i_wr(wr),
        .i_ad(ad), .i_di(di), .o_wavead(wa_b), .i_wavedt(rd_b),
        .o_pcmout(pcm_b), .o_pcmstb(stb_b), .o_busy(bsy_b), .o_ovr(ovr_b));

    namco_wsg_nvoice #(.VOICES(3), .CLK_DIV(8)) dut_c (
        .i_mclk(clk), .i_reset(rst_c), .i_snden(snden), .i_wr(wr),
        .i_ad(ad), .i_di(di), .o_wavead(wa_c), .i_wavedt(rd_c),
        .o_pcmout(pcm_c), .o_pcmstb(stb_c), .o_busy(bsy_c), .o_ovr(ovr_c));

    // Synchronous wave ROMs, one cycle latency.
    always @(posedge clk) begin
        rd_a <= rom_a_f ? 4'hF : wa_a[3:0];
        rd_b <= rom_b_f ? 4'hF : wa_b[3:0];
        rd_c <= 4'hF;
    end

    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a) busy_a = 0;
        else begin
            if (bsy_a) busy_a++;
            if (stb_a) begin
                if (q_a.size() == 0) chk("a_unexpected_strobe", 1, 0);
                else chk("a_pcmout", pcm_a, q_a.pop_front());
                chk("a_strobe_phase", n_a % 500, 9);
                chk("a_busy_cycles", busy_a, 11);
                busy_a = 0;
                pops_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b) busy_b = 0;
        else begin
            if (bsy_b) busy_b++;
            if (stb_b) begin
                if (q_b.size() == 0) chk("b_unexpected_strobe", 1, 0);
                else chk("b_pcmout", pcm_b, q_b.pop_front());
                chk("b_strobe_phase", n_b % 16, 9);
                chk("b_busy_cycles", busy_b, 11);
                busy_b = 0;
                pops_b++;
            end
        end
    end

    always @(negedge clk)
        if (!rst_c && stb_c) stb_cnt_c++;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [3:0] d);
        step();
        wr = 1'b1; ad = a; di = d;
        step();
        wr = 1'b0;
    endtask

    task automatic wait_pops(input bit use_b, input int target, input int budget);
        int k = 0;
        while ((use_b ? pops_b : pops_a) < target && k < budget) begin
            step();
            k++;
        end
        chk(use_b ? "b_strobe_count" : "a_strobe_count",
            use_b ? pops_b : pops_a, target);
    endtask

    task automatic wait_nb(input int target);
        int k = 0;
        while (n_b != target && k < 200) begin step(); k++; end
        chk("b_cycle_reached", n_b, target);
    endtask

    task automatic wait_nc(input int target);
        int k = 0;
        while (n_c != target && k < 200) begin step(); k++; end
        chk("c_cycle_reached", n_c, target);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_wavead", wa_a, 0);
        chk("rst_pcmout", pcm_a, 0);
        chk("rst_pcmstb", stb_a, 0);
        chk("rst_busy", bsy_a, 0);
        chk("rst_ovr", ovr_a, 0);

        // Nibble-2 write lands during voice 1's ACC: old step 1, new step 3.
        q_b.push_back(8'h0F);
        q_b.push_back(8'h3C);
        q_b.push_back(8'h69);
        rst_b = 1'b0;
        wr_reg(5'b01_001, 4'h8);
        wr_reg(5'b01_110, 4'hF);
        wait_nb(19);
        wr = 1'b1; ad = 5'b01_010; di = 4'h1;
        step();
        wr = 1'b0;
        wait_pops(1'b1, 3, 200);

        // Saturation with no mix shift.
        rst_b = 1'b1;
        rom_b_f = 1'b1;
        repeat (2) step();
        q_b.push_back(8'hFF);
        q_b.push_back(8'hFF);
        rst_b = 1'b0;
        wr_reg(5'b00_110, 4'hF);
        wr_reg(5'b01_110, 4'hF);
        wr_reg(5'b10_110, 4'hF);
        wait_pops(1'b1, 5, 200);
        rst_b = 1'b1;
        chk("b_ovr", ovr_b, 0);

        // Silent voices, then a single ramping voice.
        repeat (3) q_a.push_back(8'h00);
        rst_a = 1'b0;
        wait_pops(1'b0, 3, 2000);
        wr_reg(5'b00_011, 4'h8);
        wr_reg(5'b00_101, 4'h0);
        wr_reg(5'b00_110, 4'hF);
        q_a.push_back(8'h03);
        q_a.push_back(8'h07);
        q_a.push_back(8'h0B);
        q_a.push_back(8'h0F);
        wait_pops(1'b0, 7, 2500);

        snden = 1'b0;
        repeat (4) q_a.push_back(8'h00);
        wait_pops(1'b0, 11, 2500);
        snden = 1'b1;
        q_a.push_back(8'h12);
        wait_pops(1'b0, 12, 700);

        wr_reg(5'b01_110, 4'hF);
        wr_reg(5'b10_110, 4'hF);
        rom_a_f = 1'b1;
        wr_reg(5'b11_110, 4'h0);
        wr_reg(5'b00_111, 4'h0);
        q_a.push_back(8'hA8);
        q_a.push_back(8'hA8);
        wait_pops(1'b0, 14, 1200);
        chk("a_ovr", ovr_a, 0);
        rst_a = 1'b1;

        // Overrunning divider, then reset in the middle of MAC.
        rst_c = 1'b0;
        wr_reg(5'b00_110, 4'hF);
        wait_nc(26);
        chk("c_ovr_sticky", ovr_c, 1);
        chk("c_first_sample", pcm_c, 8'h38);
        chk("c_busy_in_mac", bsy_c, 1);
        chk("c_strobes_before_reset", stb_cnt_c, 1);
        rst_c = 1'b1;
        step();
        chk("c_rst_busy", bsy_c, 0);
        chk("c_rst_pcmout", pcm_c, 0);
        chk("c_rst_ovr", ovr_c, 0);
        chk("c_rst_pcmstb", stb_c, 0);
        chk("c_rst_wavead", wa_c, 0);
        step();
        rst_c = 1'b0;
        repeat (4) step();
        chk("c_no_strobe_after_reset", stb_cnt_c, 1);
        chk("c_ovr_after_reset", ovr_c, 0);
        rst_c = 1'b1;

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/namco_wsg_nvoice.md
Name: namco_wsg_nvoice

Overview:
Parametrised successor to the fixed 3-voice wave sound generator in the Namco I/O device. It provides N time-multiplexed voices, a nibble-wide CPU register file, and a shared 4-bit wave ROM port, and produces an 8-bit mixed PCM sample once per sample tick. It sits on the common I/O device bus next to the wave ROM and drives the top-level SOUT register through PCMOUT/PCMSTB.

Parameters:
VOICES, 3, number of voices (1..8)
ACC_W, 20, phase accumulator/frequency width (multiple of 4, 8..20)
CLK_DIV, 500, MCLK cycles per sample tick (48 MHz/500 = 96 kHz); must be >= 3*VOICES+2
MIX_SHIFT, $clog2(VOICES), right shift applied to the voice sum before saturation

Ports:
MCLK  in  1  master clock, 48 MHz
RESET  in  1  synchronous, active-high reset
SNDEN  in  1  global sound enable
WR  in  1  register write strobe, one MCLK cycle
AD  in  $clog2(VOICES)+3  {voice, field} register address
DI  in  4  write data nibble
WAVEAD  out  8  wave ROM address {waveform[2:0], phase[4:0]}
WAVEDT  in  4  wave ROM data; synchronous ROM on MCLK, 1-cycle latency
PCMOUT  out  8  mixed sample
PCMSTB  out  1  one-cycle pulse when PCMOUT updates
BUSY  out  1  high while the sequencer is not IDLE
OVR  out  1  sticky overrun flag

Behaviour:
- Reset: all registers, accumulators, divider, sum and PCMOUT = 0. WAVEAD = 0, PCMSTB = 0, BUSY = 0, OVR = 0, FSM = IDLE. Reset mid-sequence aborts the sequence with no strobe.
- Register fields per voice:
  - Fields 0..4 are frequency nibbles, LSB first. Nibbles at index >= ACC_W/4 are ignored.
  - Field 5 is the waveform select (DI[2:0]).
  - Field 6 is the volume (DI[3:0]).
  - Field 7 is reserved; writes are ignored.
  - Writes to a voice index >= VOICES are ignored.
- Writes take effect on the next MCLK edge. A write to a voice currently in ACC applies to the next sample.
- Divider: counts 0..CLK_DIV-1 and wraps. On wrap it emits a one-cycle tick. The divider runs regardless of SNDEN.
- FSM states: IDLE, ACC, WAIT, MAC, OUT. Voice index v is cleared in IDLE.
  - IDLE: on tick, clear sum and go to ACC.
  - ACC: if SNDEN, acc[v] <= acc[v]+freq[v] (mod 2^ACC_W); otherwise acc[v] is held. WAVEAD <= {wave[v], new acc[v][ACC_W-1 -: 5]}. Go to WAIT.
  - WAIT: the ROM registers its data. Go to MAC.
  - MAC: sum += WAVEDT*vol[v]. Product is 8 bits unsigned; sum width is 8+$clog2(VOICES). If v == VOICES-1 go to OUT; otherwise v++ and go to ACC.
  - OUT: PCMOUT <= SNDEN ? min(sum >> MIX_SHIFT, 255) : 0. PCMSTB = 1 for this cycle only. Go to IDLE.
- Latency: with the tick seen in IDLE at cycle 0, PCMSTB is high at cycle 3*VOICES+1.
- A tick arriving while not in IDLE is dropped and sets OVR. OVR is cleared only by RESET.
- Accumulator wrap-around is silent (modular).

Decomposition:
- Package wsg_pkg holds:
  - the FSM state enum
  - field offsets F_FREQ0..F_FREQ4, F_WAVE, F_VOL
  - localparams VIDX_W = $clog2(VOICES) and SUM_W.
- Sub-module wsg_voice_regs holds the register file (freq/wave/vol arrays, write decode, voice-index read mux). Sequencer, divider and mixer stay in the top module.

Test Plan:
1. Reset, then VOICES=3 with all vol=0 and SNDEN=1 -> PCMSTB every 500 cycles, PCMOUT=0x00, OVR=0, BUSY high for exactly 11 cycles per tick.
2. Voice 0: freq=0x08000, wave=0, vol=15; ROM model returns addr[3:0] -> sample k (k=1,2,...) gives PCMOUT=((k&15)*15)>>2. First strobe = 0x03, second = 0x07; strobe 10 cycles after the tick.
3. All 3 voices: vol=15, ROM returns 0xF -> sum=675, >>2=168 -> PCMOUT=0xA8. With MIX_SHIFT=0 the output saturates to PCMOUT=0xFF.
4. SNDEN=0 for 4 ticks, then 1 -> PCMOUT=0x00 during the disabled ticks. acc[0] unchanged, and the first enabled sample matches the stream resumed from where it stopped.
5. Frequency write to voice 1 nibble 2 during its ACC cycle -> the old freq is used this sample, the new freq from the next. Write to AD with voice index 3 or field 7 -> no state change.
6. CLK_DIV=8 with VOICES=3 (illegal) -> a tick during busy sets OVR=1 and it stays set. Assert RESET mid-MAC -> next cycle FSM=IDLE, PCMOUT=0, OVR=0, no PCMSTB.
